// File: rtl/alu_pkg.sv
// Shared ALU definitions: command encodings and default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    // Only the arithmetic commands carry a meaningful signed-overflow flag.
    function automatic logic is_arith(input logic [2:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO feeding the ALU; head is forced to zero (0/0/ADD) when empty.
module alu_req_fifo #(
    parameter int ENTRY_W = 67,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         wdata,
    input  logic                       pop,
    output logic [ENTRY_W-1:0]         head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    // Pointers are exactly PW bits, so increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage around an external combinational ALU: request FIFO in, one registered result slot out.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [2:0]             in_cmd,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_cmd,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_carryout,
    input  logic                   alu_zero,
    input  logic                   alu_overflow,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic                   out_carryout,
    output logic                   out_zero,
    output logic                   out_overflow,
    output logic [2:0]             out_cmd,
    output logic                   sticky_ovf,
    input  logic                   clr_sticky,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * WIDTH + 3;

    logic [EW-1:0] head;
    logic          push;
    logic          pop;
    logic          ovf_hit;

    // in_ready depends on occupancy only, so no combinational path from in_valid/out_ready.
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (count != '0) & (~out_valid | out_ready);

    alu_req_fifo #(
        .ENTRY_W (EW),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({in_cmd, in_a, in_b}),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    assign {alu_cmd, alu_a, alu_b} = head;

    assign ovf_hit = pop & alu_overflow & is_arith(alu_cmd);

    // Output register: FIFO head -> ALU -> here is the single-cycle path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carryout <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_cmd      <= CMD_ADD;
        end else if (pop) begin
            out_valid    <= 1'b1;
            out_result   <= alu_result;
            out_carryout <= alu_carryout;
            out_zero     <= alu_zero;
            out_overflow <= alu_overflow;
            out_cmd      <= alu_cmd;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // A new overflow wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (ovf_hit) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU attached to its alu_* ports.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] r;
        logic        co;
        logic        z;
        logic        ov;
        logic [2:0]  cmd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_cmd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_cmd;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_zero;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carryout;
    logic        out_zero;
    logic        out_overflow;
    logic [2:0]  out_cmd;
    logic        sticky_ovf;
    logic        clr_sticky;
    logic [2:0]  count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_cmd       (in_cmd),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cmd      (alu_cmd),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carryout (out_carryout),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_cmd      (out_cmd),
        .sticky_ovf   (sticky_ovf),
        .clr_sticky   (clr_sticky),
        .count        (count)
    );

    // Reference ALU behaviour, straight from the command definitions.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        exp_t        e;
        logic [32:0] s;
        e     = '0;
        e.cmd = cmd;
        case (cmd)
            3'd0: begin
                s    = {1'b0, a} + {1'b0, b};
                e.r  = s[31:0];
                e.co = s[32];
                e.ov = (a[31] == b[31]) && (e.r[31] != a[31]);
            end
            3'd1: begin
                s    = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.r  = s[31:0];
                e.co = s[32];
                e.ov = (a[31] != b[31]) && (e.r[31] != a[31]);
            end
            3'd2:    e.r = a ^ b;
            3'd3:    e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4:    e.r = a & b;
            3'd5:    e.r = ~(a & b);
            3'd6:    e.r = ~(a | b);
            default: e.r = a | b;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] r, input logic co, input logic z,
                                input logic ov, input logic [2:0] cmd);
        exp_t e;
        e.r = r; e.co = co; e.z = z; e.ov = ov; e.cmd = cmd;
        return e;
    endfunction

    always_comb begin
        exp_t e;
        e            = model(alu_a, alu_b, alu_cmd);
        alu_result   = e.r;
        alu_carryout = e.co;
        alu_zero     = e.z;
        alu_overflow = e.ov;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every accepted output is matched against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_result", {32'd0, out_result}, {32'd0, e.r});
                check("out_flags", {61'd0, out_carryout, out_zero, out_overflow}, {61'd0, e.co, e.z, e.ov});
                check("out_cmd", {61'd0, out_cmd}, {61'd0, e.cmd});
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting rise.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd, input exp_t e);
        int waited;
        in_a     = a;
        in_b     = b;
        in_cmd   = cmd;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        else exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        c = 3'($urandom_range(0, 7));
        send(a, b, c, model(a, b, c));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) @(negedge clk);
        check("drain_empty", {63'd0, (exp_q.size() == 0) && !out_valid}, 64'd1);
    endtask

    task automatic set_out_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held;
        int          acc;
        logic [31:0] bp_a [7];
        logic [31:0] bp_b [7];
        logic [2:0]  bp_c [7];
        bit          done;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cmd = '0;
        out_ready = 1'b1; clr_sticky = 1'b0;
        #1;
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
        check("rst_alu_in", {alu_a, alu_b} | {61'd0, alu_cmd}, 64'd0);
        #11 rst_n = 1'b1;
        @(negedge clk);

        // Single ADD and its latency.
        send(32'h8000_0288, 32'd483001, 3'd0, mk(32'h8007_6141, 1'b0, 1'b0, 1'b0, 3'd0));
        check("add_not_yet_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("add_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);

        // Back-to-back logic operations.
        send(32'hAAAA_F0F0, 32'h5555_0FF0, 3'd4, mk(32'h0000_00F0, 1'b0, 1'b0, 1'b0, 3'd4));
        send(32'hAAAA_F0F0, 32'h5555_0FF0, 3'd5, mk(32'hFFFF_FF0F, 1'b0, 1'b0, 1'b0, 3'd5));
        send(32'hAAAA_F0F0, 32'h5555_0FF0, 3'd7, mk(32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 3'd7));
        send(32'hAAAA_F0F0, 32'h5555_0FF0, 3'd6, mk(32'h0000_000F, 1'b0, 1'b0, 1'b0, 3'd6));
        send(32'hAAAA_F0F0, 32'h5555_0FF0, 3'd2, mk(32'hFFFF_FF00, 1'b0, 1'b0, 1'b0, 3'd2));
        check("b2b_valid4", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        check("b2b_valid5", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        check("b2b_done", {63'd0, out_valid || exp_q.size() != 0}, 64'd0);

        // Sticky overflow set, set-with-clear, lone clear.
        send(32'h7FFF_FFFF, 32'd1, 3'd0, mk(32'h8000_0000, 1'b0, 1'b0, 1'b1, 3'd0));
        @(negedge clk);
        check("sticky_set", {63'd0, sticky_ovf}, 64'd1);
        send(32'h8000_0000, 32'd1, 3'd1, mk(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 3'd1));
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("sticky_set_and_clr", {63'd0, sticky_ovf}, 64'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("sticky_clr", {63'd0, sticky_ovf}, 64'd0);

        // SLT.
        send(32'h8000_0288, 32'd483001, 3'd3, mk(32'd1, 1'b0, 1'b0, 1'b0, 3'd3));
        send(32'h7FFF_FD78, 32'd483001, 3'd3, mk(32'd0, 1'b0, 1'b1, 1'b0, 3'd3));
        drain();

        // Backpressure: 7 offered, 4 in FIFO + 1 in output register.
        for (int i = 0; i < 7; i++) begin
            bp_a[i] = $urandom; bp_b[i] = $urandom; bp_c[i] = 3'($urandom_range(0, 7));
        end
        set_out_ready(1'b0);
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            in_a = bp_a[acc]; in_b = bp_b[acc]; in_cmd = bp_c[acc]; in_valid = 1'b1;
            if (in_ready) begin
                exp_q.push_back(model(bp_a[acc], bp_b[acc], bp_c[acc]));
                acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'd5);
        check("bp_count", {61'd0, count}, 64'd4);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        held = out_result;
        repeat (3) @(negedge clk);
        check("bp_stable", {31'd0, out_valid, out_result}, {31'd0, 1'b1, held});
        set_out_ready(1'b1);
        for (int i = 0; i < 4; i++) begin
            check("bp_stream_valid", {63'd0, out_valid}, 64'd1);
            @(negedge clk);
        end
        check("bp_stream_last", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        check("bp_done", {63'd0, out_valid || exp_q.size() != 0}, 64'd0);

        // Randomised traffic with random consumer stalls.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send_rand();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        #1 out_ready = 1'b1;
        @(negedge clk);
        drain();

        // Mid-stream reset with a captured result and three queued requests.
        set_out_ready(1'b0);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'd0, model(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'd0));
        send_rand();
        send_rand();
        send_rand();
        check("pre_rst_state", {60'd0, count, out_valid}, {60'd0, 3'd3, 1'b1});
        check("pre_rst_sticky", {63'd0, sticky_ovf}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", {61'd0, count}, 64'd0);
        check("mid_rst_flags", {60'd0, out_valid, in_ready, sticky_ovf, out_overflow}, 64'b0100);
        check("mid_rst_out", {29'd0, out_cmd, out_result}, 64'd0);
        check("mid_rst_alu_in", {alu_a, alu_b} | {61'd0, alu_cmd}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send(32'd5, 32'd7, 3'd1, model(32'd5, 32'd7, 3'd1));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Request-issue and result-capture stage around the 32-bit combinational ALU.
- Accepts operation requests (operand A, operand B, 3-bit command) on a valid/ready handshake and buffers them in a small FIFO.
- Drives the FIFO head onto the ALU inputs.
- Registers the ALU result and flags into a single output register with its own valid/ready handshake.
- The ALU is instantiated beside this block, not inside it. This block is the ALU's immediate upstream feeder and downstream consumer.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- DEPTH, 4, request FIFO entries; power of two, ≥2

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request offered
- in_ready  out  1  request FIFO not full
- in_a, in_b  in  WIDTH  operands
- in_cmd  in  3  ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7
- alu_a, alu_b  out  WIDTH  to ALU operandA/operandB
- alu_cmd  out  3  to ALU command
- alu_result  in  WIDTH  from ALU
- alu_carryout, alu_zero, alu_overflow  in  1  from ALU
- out_valid  out  1  captured result available
- out_ready  in  1  consumer accepts
- out_result  out  WIDTH  captured result
- out_carryout, out_zero, out_overflow  out  1  captured flags, unmodified
- out_cmd  out  3  command that produced out_result
- sticky_ovf  out  1  an overflowing ADD/SUB has been captured
- clr_sticky  in  1  clears sticky_ovf
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
Handshake events:
- push = in_valid & in_ready.
- pop = (count≠0) & (!out_valid | out_ready).
- in_ready = (count<DEPTH). It is combinational from count only, with no push-through on full.

Data flow:
- alu_a/alu_b/alu_cmd come combinationally from the FIFO head. When empty they are 0/0/ADD.
- On pop, out_result, the flags and out_cmd load from the ALU outputs and head command, and out_valid becomes 1.
- On out_valid & out_ready without pop, out_valid becomes 0. Data regs hold their last value.
- Push and pop in the same cycle leave count unchanged; the push writes the tail and the pop advances the head.
- Push when count=0 is legal. The entry reaches the ALU the next cycle.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

Sticky overflow:
- sticky_ovf is set on a pop with alu_overflow=1 and head cmd ∈ {ADD, SUB}.
- It is cleared by clr_sticky.
- Set and clear in the same cycle leaves it set.

Ordering and control:
- Results leave in request order. Nothing is dropped or reordered.
- No state machine beyond FIFO pointers plus the out_valid bit.

## Timing
Reset values (while rst_n=0, asynchronous):
- count=0, pointers=0, out_valid=0, out_result=0, out flags=0, out_cmd=0, sticky_ovf=0.
- in_ready=1 and alu_* = 0/0/ADD.

Throughput and latency:
- Latency: request accepted at edge N → out_valid=1 after edge N+1, when the output register is free or draining.
- Throughput: one request per cycle sustained with out_ready=1.

Backpressure:
- With out_ready=0, capacity is DEPTH in the FIFO plus 1 in the output register.
- Output data is stable while out_valid & !out_ready.

Timing path:
- The ALU is combinational, so FIFO head reg → ALU → output reg is one cycle path.
- out_ready and in_valid have no combinational path to in_ready.

Mid-operation reset:
- Reset mid-stream discards all queued and captured requests immediately.
- The first edge after deassertion behaves as after power-up.

## Structure
- Shared package alu_pkg: command encodings ADD..OR as 3-bit localparams, default WIDTH.
- Sub-module alu_req_fifo: synchronous FIFO, (WIDTH*2+3)-bit entries, DEPTH deep.
  - Exposes push/pop/head/count.
  - Uses the same clk/rst_n.
- Top level holds the pop logic, output register and sticky flag.

## Test plan
- Reset: assert rst_n low with 3 queued and out_valid=1 → same cycle count=0, out_valid=0, in_ready=1, sticky_ovf=0.
- Single ADD: a=-2147483000, b=483001, out_ready=1 → out_valid two edges after accept, out_result=-2146999999, co=0 ov=0 z=0, out_cmd=0.
- Back-to-back logic ops:
  - Stimulus: a=0xAAAAF0F0, b=0x55550FF0, AND/NAND/OR/NOR/XOR with out_ready=1.
  - Required: results on consecutive cycles 0x000000F0, 0xFFFFFF0F, 0xFFFFFFF0, 0x0000000F, 0xFFFFFF00.
- Backpressure:
  - Stimulus: out_ready=0, offer 7 requests with DEPTH=4.
  - Required: 5 accepted, then in_ready=0 with count=4, and out_result stable.
  - Then: release out_ready → all 5 emerge in order, one per cycle.
- Sticky:
  - ADD 0x7FFFFFFF+1 → out_result=0x80000000, ov=1, and sticky_ovf=1 next cycle.
  - clr_sticky in the same cycle as a second overflowing SUB (0x80000000-1) pop → sticky_ovf stays 1.
  - Lone clr_sticky → 0.
- SLT:
  - -2147483000 vs 483001 → out_result=1, z=0.
  - 2147483000 vs 483001 → out_result=0, z=1.
